// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if -- CPU data-bus slice used by the memory-mapped UART
// transmitter.
//
// Handshake: the bus has no valid/ready pair. It is a single-cycle strobe
// protocol. dm_w or dm_r high in a cycle is the request. The slave always
// completes the request in that same cycle, so there is no back-pressure and
// no wait state. A store takes effect on the rising clk edge that ends the
// cycle. Load data (rdata) and the address decode (hit) are combinational
// from the request inside the same cycle.
//
// Signals:
//   dm_w   master->slave  store strobe
//   dm_r   master->slave  load strobe
//   addr   master->slave  32-bit byte address
//   wdata  master->slave  32-bit store data
//   dm_op  master->slave  access width (word assumed by this slave)
//   rdata  slave->master  32-bit load data, zero when not selected
//   hit    slave->master  address decodes to the slave's register block
interface uart_tx_mmio_if;
    logic        dm_w;
    logic        dm_r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_op;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output dm_w, dm_r, addr, wdata, dm_op,
        input  rdata, hit
    );

    modport slave (
        input  dm_w, dm_r, addr, wdata, dm_op,
        output rdata, hit
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio -- memory-mapped 8N1 UART transmitter with a 4-entry TX FIFO.
//
// Register block (word-spaced, addr[3:2]):
//   0 TXDATA  write-only, pushes wdata[7:0] into the FIFO; reads 0
//   1 STATUS  {ovf, count[2:0], empty, full, busy}; any write clears ovf
//   2 BAUDDIV clk cycles per serial bit, bits[15:0]; 0 behaves as 1
//   3 CTRL    bit0 en: allows the FSM to take bytes from the FIFO
//
// Ports:
//   clk        rising-edge clock
//   rest       asynchronous active-high reset
//   bus        CPU data-bus slave (see uart_tx_mmio_if)
//   tx         serial output, idle high
//   irq        FIFO empty, enabled and transmitter idle
//   dbg_state  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module uart_tx_mmio #(
    parameter logic [31:0] BASE    = 32'h0000_FF00,
    parameter logic [15:0] DIV_RST = 16'd434
) (
    input  logic          clk,
    input  logic          rest,
    uart_tx_mmio_if.slave bus,
    output logic          tx,
    output logic          irq,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [1:0] reg_sel;
    logic       acc_wr;
    logic       acc_rd;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_baud;
    logic       wr_ctrl;

    assign bus.hit   = (bus.addr[31:4] == BASE[31:4]);
    assign reg_sel   = bus.addr[3:2];
    assign acc_wr    = bus.dm_w & bus.hit;
    assign acc_rd    = bus.dm_r & bus.hit;
    assign wr_txdata = acc_wr & (reg_sel == REG_TXDATA);
    assign wr_status = acc_wr & (reg_sel == REG_STATUS);
    assign wr_baud   = acc_wr & (reg_sel == REG_BAUDDIV);
    assign wr_ctrl   = acc_wr & (reg_sel == REG_CTRL);

    // Width, byte offset and upper store bits carry no meaning for this block.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.dm_op, bus.addr[1:0], bus.wdata[31:16]};

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [15:0] baud_div_q;
    logic        en_q;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            baud_div_q <= DIV_RST;
            en_q       <= 1'b0;
        end else begin
            if (wr_baud) begin
                baud_div_q <= bus.wdata[15:0];
            end
            if (wr_ctrl) begin
                en_q <= bus.wdata[0];
            end
        end
    end

    // Reload value for the down-counting baud counter. A divider of 0 gives
    // the same one-cycle bit as a divider of 1.
    logic [15:0] bit_reload;
    assign bit_reload = (baud_div_q == 16'd0) ? 16'd0 : (baud_div_q - 16'd1);

    // ------------------------------------------------------------------
    // TX FIFO: 4 x 8. The occupancy count is kept apart from the pointers,
    // so full and empty never depend on comparing the wrapping pointers.
    // ------------------------------------------------------------------
    logic [7:0] fifo_mem [4];
    logic [1:0] wptr_q;
    logic [1:0] rptr_q;
    logic [2:0] count_q;
    logic       ovf_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       push;
    logic       overflow;
    logic [7:0] fifo_head;

    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    // When the FIFO is full, a pop in the same cycle frees the slot being
    // written, so the store is still accepted.
    assign push       = wr_txdata & (~fifo_full | pop);
    assign overflow   = wr_txdata & fifo_full & ~pop;
    assign fifo_head  = fifo_mem[rptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            if (push && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 3'd1;
            end
            if (overflow) begin
                ovf_q <= 1'b1;
            end else if (wr_status) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic [15:0] baud_cnt_q;
    logic [15:0] baud_cnt_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [2:0]  bit_idx_q;
    logic [2:0]  bit_idx_d;
    logic        bit_done;
    logic        can_start;

    // The counter holds the cycles still left in the current bit. It is
    // loaded only at a bit boundary, so a BAUDDIV store in the middle of a
    // bit takes effect from the next bit.
    assign bit_done  = (baud_cnt_q == 16'd0);
    assign can_start = en_q & ~fifo_empty;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        pop        = 1'b0;
        tx         = 1'b1;

        case (state_q)
            S_IDLE: begin
                tx = 1'b1;
                if (can_start) begin
                    pop        = 1'b1;
                    shift_d    = fifo_head;
                    baud_cnt_d = bit_reload;
                    state_d    = S_START;
                end
            end

            S_START: begin
                tx = 1'b0;
                if (bit_done) begin
                    baud_cnt_d = bit_reload;
                    bit_idx_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end

            S_DATA: begin
                tx = shift_q[0];
                if (bit_done) begin
                    baud_cnt_d = bit_reload;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end

            S_STOP: begin
                tx = 1'b1;
                if (bit_done) begin
                    // A queued byte goes straight to START without an
                    // extra idle cycle on the line. A cleared en stops
                    // here after the current frame.
                    if (can_start) begin
                        pop        = 1'b1;
                        shift_d    = fifo_head;
                        baud_cnt_d = bit_reload;
                        state_d    = S_START;
                    end else begin
                        baud_cnt_d = 16'd0;
                        state_d    = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status, interrupt, read mux
    // ------------------------------------------------------------------
    logic        busy;
    logic [31:0] status_word;

    assign busy        = (state_q != S_IDLE);
    assign status_word = {25'd0, ovf_q, count_q, fifo_empty, fifo_full, busy};
    assign irq         = fifo_empty & en_q & (state_q == S_IDLE);
    assign dbg_state   = state_q;

    // A load that coincides with a store returns the value held before the
    // store's clock edge, because this path reads the registered state.
    always_comb begin
        bus.rdata = 32'h0;
        if (acc_rd) begin
            case (reg_sel)
                REG_STATUS:  bus.rdata = status_word;
                REG_BAUDDIV: bus.rdata = {16'd0, baud_div_q};
                REG_CTRL:    bus.rdata = {31'd0, en_q};
                default:     bus.rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio -- directed bench for uart_tx_mmio.
// The stimulus pushes expected load results and expected serial frames into
// queues. Two monitors pop those queues and compare them with what the DUT
// presents on the bus and on the tx line.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE      = 32'h0000_FF00;
    localparam logic [15:0] DIV_RST   = 16'd434;
    localparam logic [31:0] A_TXDATA  = BASE + 32'd0;
    localparam logic [31:0] A_STATUS  = BASE + 32'd4;
    localparam logic [31:0] A_BAUDDIV = BASE + 32'd8;
    localparam logic [31:0] A_CTRL    = BASE + 32'd12;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rest;
    logic       tx;
    logic       irq;
    logic [1:0] dbg_state;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(.BASE(BASE), .DIV_RST(DIV_RST)) dut (
        .clk       (clk),
        .rest      (rest),
        .bus       (bus),
        .tx        (tx),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] exp_rd_q[$];   // {hit, rdata}
    string       exp_rd_nm[$];
    // {byte[7:0], div_a[7:0], div_b[7:0], sw[3:0]}: frame bits with index
    // >= sw (0 start, 1..8 data, 9 stop) last div_b cycles when sw != 0.
    logic [27:0] exp_tx_q[$];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising clk edge.
    task automatic bus_idle();
        bus.dm_w  = 1'b0;
        bus.dm_r  = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.dm_op = 3'd2;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.dm_w  = 1'b1;
        bus.dm_r  = 1'b0;
        bus.dm_op = 3'($urandom_range(0, 7));
        cycles(1);
        bus_idle();
    endtask

    task automatic bus_read(input string name, input logic [31:0] a,
                            input logic exp_hit, input logic [31:0] exp_data);
        exp_rd_q.push_back({exp_hit, exp_data});
        exp_rd_nm.push_back(name);
        bus.addr  = a;
        bus.dm_r  = 1'b1;
        bus.dm_w  = 1'b0;
        bus.dm_op = 3'($urandom_range(0, 7));
        cycles(1);
        bus_idle();
    endtask

    task automatic bus_rw(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data);
        exp_rd_q.push_back({1'b1, exp_data});
        exp_rd_nm.push_back(name);
        bus.addr  = a;
        bus.wdata = d;
        bus.dm_r  = 1'b1;
        bus.dm_w  = 1'b1;
        cycles(1);
        bus_idle();
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic [7:0] div_a,
                                input logic [7:0] div_b, input logic [3:0] sw);
        exp_tx_q.push_back({b, div_a, div_b, sw});
    endtask

    task automatic wait_irq(input string name, input int budget);
        int k;
        k = 0;
        while (irq !== 1'b1 && k < budget) begin
            cycles(1);
            k++;
        end
        check(name, {32'd0, irq}, 33'd1);
    endtask

    task automatic wait_data(input string name, input int budget);
        int k;
        k = 0;
        while (dbg_state !== 2'd2 && k < budget) begin
            cycles(1);
            k++;
        end
        check(name, {31'd0, dbg_state}, 33'd2);
    endtask

    // ---------------- load monitor ----------------
    initial begin : rd_mon
        logic [32:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (bus.dm_r === 1'b1) begin
                n_tests++;
                if (exp_rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: got hit=%b rdata=%h, required no load", bus.hit, bus.rdata);
                end else begin
                    e  = exp_rd_q.pop_front();
                    nm = exp_rd_nm.pop_front();
                    if ({bus.hit, bus.rdata} !== e) begin
                        n_fail++;
                        $display("FAIL %s: got hit=%b rdata=%h, required hit=%b rdata=%h",
                                 nm, bus.hit, bus.rdata, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- serial line monitor ----------------
    initial begin : tx_mon
        logic        prev;
        logic [27:0] e;
        logic [7:0]  got;
        int          bad;
        logic        lvl;
        int          dur;
        logic        aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rest === 1'b0 && prev === 1'b1 && tx === 1'b0) begin
                if (exp_tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: start bit at %0t, required idle line", $time);
                end else begin
                    e       = exp_tx_q.pop_front();
                    bad     = 0;
                    got     = 8'h00;
                    aborted = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        if (k == 0)      lvl = 1'b0;
                        else if (k == 9) lvl = 1'b1;
                        else             lvl = e[19 + k];
                        if (e[3:0] != 4'd0 && k >= int'(e[3:0])) dur = int'(e[11:4]);
                        else                                     dur = int'(e[19:12]);
                        for (int c = 0; c < dur; c++) begin
                            if (k != 0 || c != 0) begin
                                @(negedge clk);
                                if (rest !== 1'b0) aborted = 1'b1;
                            end
                            if (aborted) break;
                            if (tx !== lvl) bad++;
                            if (k >= 1 && k <= 8 && c == dur / 2) got[k - 1] = tx;
                        end
                        if (aborted) break;
                    end
                    if (!aborted) begin
                        n_tests++;
                        if (bad != 0 || got !== e[27:20]) begin
                            n_fail++;
                            $display("FAIL tx_frame: got byte %h with %0d wrong-level cycles, required byte %h with 0",
                                     got, bad, e[27:20]);
                        end
                    end
                end
            end
            prev = tx;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus_idle();
        rest = 1'b1;
        cycles(3);
        check("rst_tx",    {32'd0, tx},        33'd1);
        check("rst_irq",   {32'd0, irq},       33'd0);
        check("rst_state", {31'd0, dbg_state}, 33'd0);
        rest = 1'b0;
        cycles(1);

        // Register state after reset: STATUS = empty only.
        bus_read("rst_status",  A_STATUS,  1'b1, 32'h0000_0004);
        bus_read("rst_bauddiv", A_BAUDDIV, 1'b1, 32'h0000_01B2);
        bus_read("rst_ctrl",    A_CTRL,    1'b1, 32'h0000_0000);
        bus_read("txdata_read", A_TXDATA,  1'b1, 32'h0000_0000);
        bus.addr = A_STATUS;
        #1;
        check("rdata_no_load", {bus.hit, bus.rdata}, {1'b1, 32'h0});
        bus_idle();
        cycles(1);

        // Single 0xA5 frame at 4 cycles per bit.
        bus_write(A_BAUDDIV, 32'd4);
        bus_write(A_CTRL, 32'd1);
        expect_frame(8'hA5, 8'd4, 8'd4, 4'd0);
        bus_write(A_TXDATA, 32'h0000_00A5);
        cycles(3);
        bus_read("busy_status", A_STATUS, 1'b1, 32'h0000_0005);  // busy | empty
        check("irq_mid_frame", {32'd0, irq}, 33'd0);
        wait_irq("a5_done", 1000);

        // Overflow: five stores while disabled; the fifth is dropped.
        bus_write(A_CTRL, 32'd0);
        for (int i = 1; i <= 5; i++) bus_write(A_TXDATA, i);
        bus_read("ovf_status", A_STATUS, 1'b1, 32'h0000_0062);  // ovf | count 4 | full
        bus_write(A_STATUS, 32'h0);
        bus_read("ovf_cleared", A_STATUS, 1'b1, 32'h0000_0022);
        for (int i = 1; i <= 4; i++) expect_frame(8'(i), 8'd4, 8'd4, 4'd0);
        bus_write(A_CTRL, 32'd1);
        wait_irq("drain4_done", 2000);

        // Store into a full FIFO on the cycle the FSM pops.
        bus_write(A_CTRL, 32'd0);
        bus_write(A_TXDATA, 32'h11);
        bus_write(A_TXDATA, 32'h22);
        bus_write(A_TXDATA, 32'h33);
        bus_write(A_TXDATA, 32'h44);
        bus_read("full_status", A_STATUS, 1'b1, 32'h0000_0022);
        expect_frame(8'h11, 8'd4, 8'd4, 4'd0);
        expect_frame(8'h22, 8'd4, 8'd4, 4'd0);
        expect_frame(8'h33, 8'd4, 8'd4, 4'd0);
        expect_frame(8'h44, 8'd4, 8'd4, 4'd0);
        expect_frame(8'h55, 8'd4, 8'd4, 4'd0);
        bus_write(A_CTRL, 32'd1);
        bus_write(A_TXDATA, 32'h55);
        bus_read("push_pop_full", A_STATUS, 1'b1, 32'h0000_0023);  // busy | full | count 4
        wait_irq("drain5_done", 3000);

        // BAUDDIV 4 -> 8 in the middle of data bit 2 (frame bit 3).
        expect_frame(8'hC3, 8'd4, 8'd8, 4'd4);
        bus_write(A_TXDATA, 32'hC3);
        wait_data("reach_data_c3", 100);
        cycles(8);
        bus_write(A_BAUDDIV, 32'd8);
        wait_irq("c3_done", 1000);

        // Decode miss, and a combined load+store to CTRL.
        bus_read("miss_read", BASE + 32'd16, 1'b0, 32'h0);
        bus_write(A_CTRL, 32'd0);
        bus_rw("rw_ctrl_old", A_CTRL, 32'd1, 32'h0);
        bus_read("rw_ctrl_new", A_CTRL, 1'b1, 32'h1);
        check("irq_idle_en", {32'd0, irq}, 33'd1);

        // Reset during data bit 5 of 0x0F, with 0x77 still queued.
        bus_write(A_BAUDDIV, 32'd4);
        expect_frame(8'h0F, 8'd4, 8'd4, 4'd0);
        bus_write(A_TXDATA, 32'h0F);
        bus_write(A_TXDATA, 32'h77);
        wait_data("reach_data_0f", 100);
        cycles(21);
        check("pre_rst_tx_low", {32'd0, tx}, 33'd0);
        rest = 1'b1;
        #1;
        check("async_rst_tx", {32'd0, tx}, 33'd1);
        cycles(2);
        rest = 1'b0;
        bus_read("post_rst_status",  A_STATUS,  1'b1, 32'h0000_0004);
        bus_read("post_rst_bauddiv", A_BAUDDIV, 1'b1, 32'h0000_01B2);
        check("post_rst_irq", {32'd0, irq}, 33'd0);
        cycles(10);

        // BAUDDIV = 0 gives one-cycle bits.
        bus_write(A_BAUDDIV, 32'd0);
        bus_read("bauddiv_zero", A_BAUDDIV, 1'b1, 32'h0);
        expect_frame(8'h3C, 8'd1, 8'd1, 4'd0);
        bus_write(A_TXDATA, 32'h3C);
        bus_write(A_CTRL, 32'd1);
        wait_irq("div0_done", 200);

        cycles(20);
        check("tx_queue_drained", 33'(exp_tx_q.size()), 33'd0);
        check("rd_queue_drained", 33'(exp_rd_q.size()), 33'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
